ddr_ctrl_arbit: RTL and testbench

Command arbiter of the SDRAM controller. It sits between the init, auto-refresh, write and read engines and the SDRAM command/address pins. After initialisation it grants exactly one engine at a time, with refresh always taking priority. It then forwards that engine's registered command, bank and address to the device.

---
 rtl/ddr_ctrl_arbit_if.sv | 59 +++++
 rtl/ddr_ctrl_arbit.sv | 124 ++++++++++++
 tb/tb_ddr_ctrl_arbit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_ctrl_arbit_if.sv
// Engine-side bus of the SDRAM command arbiter: per-engine request/end/command
// inputs, grant outputs and the muxed device command/address pins.
interface ddr_ctrl_arbit_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned BA_WIDTH   = 2
);
  logic                  init_end_i;
  logic [3:0]            init_cmd_i;
  logic [BA_WIDTH-1:0]   init_ba_i;
  logic [ADDR_WIDTH-1:0] init_addr_i;

  logic                  aref_req_i;
  logic                  aref_end_i;
  logic [3:0]            aref_cmd_i;
  logic [BA_WIDTH-1:0]   aref_ba_i;
  logic [ADDR_WIDTH-1:0] aref_addr_i;
  logic                  aref_en_o;

  logic                  wr_req_i;
  logic                  wr_end_i;
  logic [3:0]            wr_cmd_i;
  logic [BA_WIDTH-1:0]   wr_ba_i;
  logic [ADDR_WIDTH-1:0] wr_addr_i;
  logic                  wr_en_o;

  logic                  rd_req_i;
  logic                  rd_end_i;
  logic [3:0]            rd_cmd_i;
  logic [BA_WIDTH-1:0]   rd_ba_i;
  logic [ADDR_WIDTH-1:0] rd_addr_i;
  logic                  rd_en_o;

  logic                  sdram_cs_n;
  logic                  sdram_ras_n;
  logic                  sdram_cas_n;
  logic                  sdram_we_n;
  logic [BA_WIDTH-1:0]   sdram_ba;
  logic [ADDR_WIDTH-1:0] sdram_addr;

  // Engines and device side
  modport master (
    output init_end_i, init_cmd_i, init_ba_i, init_addr_i,
    output aref_req_i, aref_end_i, aref_cmd_i, aref_ba_i, aref_addr_i,
    output wr_req_i, wr_end_i, wr_cmd_i, wr_ba_i, wr_addr_i,
    output rd_req_i, rd_end_i, rd_cmd_i, rd_ba_i, rd_addr_i,
    input  aref_en_o, wr_en_o, rd_en_o,
    input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );

  // Arbiter side
  modport slave (
    input  init_end_i, init_cmd_i, init_ba_i, init_addr_i,
    input  aref_req_i, aref_end_i, aref_cmd_i, aref_ba_i, aref_addr_i,
    input  wr_req_i, wr_end_i, wr_cmd_i, wr_ba_i, wr_addr_i,
    input  rd_req_i, rd_end_i, rd_cmd_i, rd_ba_i, rd_addr_i,
    output aref_en_o, wr_en_o, rd_en_o,
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/ddr_ctrl_arbit.sv
// SDRAM command arbiter: one engine granted at a time, refresh first, NOP between grants.
// Define DDR_ARB_RD_FIRST_EN to rank read above write (default: write above read).
module ddr_ctrl_arbit #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned BA_WIDTH   = 2
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  ddr_ctrl_arbit_if.slave bus
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t r_state;
  logic   r_aref_en;
  logic   r_wr_en;
  logic   r_rd_en;

  // Grants are registered with the next state so they always equal its decode.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= INIT;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      case (r_state)
        INIT: begin
          if (bus.init_end_i) r_state <= ARBIT;
        end
        ARBIT: begin
          if (bus.aref_req_i) begin
            r_state   <= AREF;
            r_aref_en <= 1'b1;
          end
`ifdef DDR_ARB_RD_FIRST_EN
          else if (bus.rd_req_i) begin
            r_state <= READ;
            r_rd_en <= 1'b1;
          end else if (bus.wr_req_i) begin
            r_state <= WRITE;
            r_wr_en <= 1'b1;
          end
`else
          else if (bus.wr_req_i) begin
            r_state <= WRITE;
            r_wr_en <= 1'b1;
          end else if (bus.rd_req_i) begin
            r_state <= READ;
            r_rd_en <= 1'b1;
          end
`endif
        end
        AREF: begin
          if (bus.aref_end_i) r_state <= ARBIT;
          else                r_aref_en <= 1'b1;
        end
        WRITE: begin
          if (bus.wr_end_i) r_state <= ARBIT;
          else              r_wr_en <= 1'b1;
        end
        READ: begin
          if (bus.rd_end_i) r_state <= ARBIT;
          else              r_rd_en <= 1'b1;
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bus.aref_en_o = r_aref_en;
  assign bus.wr_en_o   = r_wr_en;
  assign bus.rd_en_o   = r_rd_en;

  logic [3:0]            w_cmd;
  logic [BA_WIDTH-1:0]   w_ba;
  logic [ADDR_WIDTH-1:0] w_addr;

  always_comb begin
    w_cmd  = 4'b0111;
    w_ba   = '1;
    w_addr = '1;
    case (r_state)
      INIT: begin
        w_cmd  = bus.init_cmd_i;
        w_ba   = bus.init_ba_i;
        w_addr = bus.init_addr_i;
      end
      AREF: begin
        w_cmd  = bus.aref_cmd_i;
        w_ba   = bus.aref_ba_i;
        w_addr = bus.aref_addr_i;
      end
      WRITE: begin
        w_cmd  = bus.wr_cmd_i;
        w_ba   = bus.wr_ba_i;
        w_addr = bus.wr_addr_i;
      end
      READ: begin
        w_cmd  = bus.rd_cmd_i;
        w_ba   = bus.rd_ba_i;
        w_addr = bus.rd_addr_i;
      end
      default: ;
    endcase
  end

  assign bus.sdram_cs_n  = w_cmd[3];
  assign bus.sdram_ras_n = w_cmd[2];
  assign bus.sdram_cas_n = w_cmd[1];
  assign bus.sdram_we_n  = w_cmd[0];
  assign bus.sdram_ba    = w_ba;
  assign bus.sdram_addr  = w_addr;

endmodule

// File: tb/tb_ddr_ctrl_arbit.sv
// Self-checking bench for ddr_ctrl_arbit: directed scenarios plus randomized
// traffic compared against an owner-based reference model.
module tb_ddr_ctrl_arbit;
  localparam int unsigned AW = 13;
  localparam int unsigned BW = 2;
  localparam int unsigned PW = 4 + BW + AW;

`ifdef DDR_ARB_RD_FIRST_EN
  localparam bit RD_FIRST = 1'b1;
`else
  localparam bit RD_FIRST = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   total = 0;
  int   bad   = 0;

  ddr_ctrl_arbit_if #(.ADDR_WIDTH(AW), .BA_WIDTH(BW)) bus ();

  ddr_ctrl_arbit #(.ADDR_WIDTH(AW), .BA_WIDTH(BW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Owner model: -1 init, 0 nobody (NOP), 1 refresh, 2 write, 3 read
  int m_owner = -1;
  int pri [3];

  initial begin
    pri[0] = 1;
    pri[1] = RD_FIRST ? 3 : 2;
    pri[2] = RD_FIRST ? 2 : 3;
  end

  function automatic bit req_of(int e);
    case (e)
      1: return bus.aref_req_i;
      2: return bus.wr_req_i;
      3: return bus.rd_req_i;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit end_of(int e);
    case (e)
      1: return bus.aref_end_i;
      2: return bus.wr_end_i;
      3: return bus.rd_end_i;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    if (!sys_rst_n) m_owner = -1;
    else if (m_owner == -1) m_owner = bus.init_end_i ? 0 : -1;
    else if (m_owner == 0) begin
      for (int k = 0; k < 3; k++)
        if (m_owner == 0 && req_of(pri[k])) m_owner = pri[k];
    end else if (end_of(m_owner)) m_owner = 0;
  end

  function automatic logic [2:0] exp_grant();
    case (m_owner)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [PW-1:0] exp_pins();
    logic [BW-1:0] ones_ba;
    logic [AW-1:0] ones_ad;
    ones_ba = '1;
    ones_ad = '1;
    case (m_owner)
      -1: return {bus.init_cmd_i, bus.init_ba_i, bus.init_addr_i};
      1:  return {bus.aref_cmd_i, bus.aref_ba_i, bus.aref_addr_i};
      2:  return {bus.wr_cmd_i, bus.wr_ba_i, bus.wr_addr_i};
      3:  return {bus.rd_cmd_i, bus.rd_ba_i, bus.rd_addr_i};
      default: return {4'b0111, ones_ba, ones_ad};
    endcase
  endfunction

  function automatic logic [2:0] grant();
    return {bus.aref_en_o, bus.wr_en_o, bus.rd_en_o};
  endfunction

  function automatic logic [3:0] cmd();
    return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
  endfunction

  function automatic logic [PW-1:0] pins();
    return {cmd(), bus.sdram_ba, bus.sdram_addr};
  endfunction

  task automatic cyc();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    bus.init_end_i  = 1'b0;
    bus.init_cmd_i  = 4'b0010;
    bus.init_ba_i   = 2'b01;
    bus.init_addr_i = 13'h00ab;
    cyc();
    total++;
    if (grant() !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", grant()); end
    total++;
    if (pins() !== {4'b0010, 2'b01, 13'h00ab}) begin
      bad++; $display("FAIL reset_pins got=%h exp=%h", pins(), {4'b0010, 2'b01, 13'h00ab});
    end
    sys_rst_n = 1'b1;
    cyc();
    total++;
    if (cmd() !== 4'b0010) begin bad++; $display("FAIL init_hold_cmd got=%b exp=0010", cmd()); end
    bus.init_end_i = 1'b1;
    cyc();
    total++;
    if (pins() !== {4'b0111, 2'b11, 13'h1fff}) begin
      bad++; $display("FAIL init_to_nop got=%h exp=%h", pins(), {4'b0111, 2'b11, 13'h1fff});
    end
    total++;
    if (grant() !== 3'b000) begin bad++; $display("FAIL arbit_grant got=%b exp=000", grant()); end
  endtask

  task automatic test_refresh();
    bus.aref_cmd_i  = 4'b0001;
    bus.aref_ba_i   = 2'b10;
    bus.aref_addr_i = 13'h0400;
    bus.aref_req_i  = 1'b1;
    cyc();
    total++;
    if (grant() !== 3'b100) begin bad++; $display("FAIL aref_grant got=%b exp=100", grant()); end
    total++;
    if (pins() !== {4'b0001, 2'b10, 13'h0400}) begin
      bad++; $display("FAIL aref_pins got=%h exp=%h", pins(), {4'b0001, 2'b10, 13'h0400});
    end
    bus.aref_req_i = 1'b0;
    bus.aref_end_i = 1'b1;
    cyc();
    bus.aref_end_i = 1'b0;
    total++;
    if (grant() !== 3'b000 || cmd() !== 4'b0111) begin
      bad++; $display("FAIL aref_release grant=%b cmd=%b exp=000/0111", grant(), cmd());
    end
  endtask

  task automatic test_contention();
    logic [2:0] order [3];
    order[0] = 3'b100;
    order[1] = RD_FIRST ? 3'b001 : 3'b010;
    order[2] = RD_FIRST ? 3'b010 : 3'b001;
    bus.aref_req_i = 1'b1;
    bus.wr_req_i   = 1'b1;
    bus.rd_req_i   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (grant() !== order[k]) begin
        bad++; $display("FAIL contention_grant%0d got=%b exp=%b", k, grant(), order[k]);
      end
      if (grant() == 3'b100) begin bus.aref_req_i = 1'b0; bus.aref_end_i = 1'b1; end
      if (grant() == 3'b010) begin bus.wr_req_i = 1'b0;   bus.wr_end_i = 1'b1;   end
      if (grant() == 3'b001) begin bus.rd_req_i = 1'b0;   bus.rd_end_i = 1'b1;   end
      cyc();
      bus.aref_end_i = 1'b0;
      bus.wr_end_i   = 1'b0;
      bus.rd_end_i   = 1'b0;
      total++;
      if (grant() !== 3'b000 || cmd() !== 4'b0111) begin
        bad++; $display("FAIL contention_nop%0d grant=%b cmd=%b exp=000/0111", k, grant(), cmd());
      end
    end
    bus.aref_req_i = 1'b0;
    bus.wr_req_i   = 1'b0;
    bus.rd_req_i   = 1'b0;
  endtask

  task automatic test_no_preempt();
    bus.wr_req_i = 1'b1;
    cyc();
    total++;
    if (grant() !== 3'b010) begin bad++; $display("FAIL wr_grant got=%b exp=010", grant()); end
    bus.wr_req_i   = 1'b0;
    bus.aref_req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (grant() !== 3'b010) begin bad++; $display("FAIL no_preempt%0d got=%b exp=010", k, grant()); end
    end
    bus.wr_end_i = 1'b1;
    cyc();
    bus.wr_end_i = 1'b0;
    total++;
    if (grant() !== 3'b000) begin bad++; $display("FAIL wr_release got=%b exp=000", grant()); end
    cyc();
    total++;
    if (grant() !== 3'b100) begin bad++; $display("FAIL aref_after_wr got=%b exp=100", grant()); end
    bus.aref_req_i = 1'b0;
    bus.aref_end_i = 1'b1;
    cyc();
    bus.aref_end_i = 1'b0;
  endtask

  task automatic test_stray_end();
    bus.rd_cmd_i  = 4'b0101;
    bus.rd_ba_i   = 2'b11;
    bus.rd_addr_i = 13'h0123;
    bus.rd_req_i  = 1'b1;
    cyc();
    bus.rd_req_i   = 1'b0;
    bus.wr_end_i   = 1'b1;
    bus.aref_end_i = 1'b1;
    cyc();
    bus.wr_end_i   = 1'b0;
    bus.aref_end_i = 1'b0;
    total++;
    if (grant() !== 3'b001) begin bad++; $display("FAIL stray_end_grant got=%b exp=001", grant()); end
    total++;
    if (pins() !== {4'b0101, 2'b11, 13'h0123}) begin
      bad++; $display("FAIL stray_end_pins got=%h exp=%h", pins(), {4'b0101, 2'b11, 13'h0123});
    end
    bus.rd_end_i = 1'b1;
    cyc();
    bus.rd_end_i = 1'b0;
    total++;
    if (grant() !== 3'b000) begin bad++; $display("FAIL rd_release got=%b exp=000", grant()); end
  endtask

  task automatic test_mid_reset();
    bus.init_cmd_i = 4'b1000;
    bus.aref_req_i = 1'b1;
    cyc();
    total++;
    if (grant() !== 3'b100) begin bad++; $display("FAIL mid_aref_grant got=%b exp=100", grant()); end
    sys_rst_n = 1'b0;
    cyc();
    total++;
    if (grant() !== 3'b000 || cmd() !== 4'b1000) begin
      bad++; $display("FAIL mid_reset grant=%b cmd=%b exp=000/1000", grant(), cmd());
    end
    sys_rst_n = 1'b1;
    cyc();
    total++;
    if (grant() !== 3'b000 || cmd() !== 4'b0111) begin
      bad++; $display("FAIL reenter_arbit grant=%b cmd=%b exp=000/0111", grant(), cmd());
    end
    cyc();
    total++;
    if (grant() !== 3'b100) begin bad++; $display("FAIL regrant_aref got=%b exp=100", grant()); end
    bus.aref_req_i = 1'b0;
    bus.aref_end_i = 1'b1;
    cyc();
    bus.aref_end_i = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      sys_rst_n       = ($urandom_range(0, 39) != 0);
      bus.init_end_i  = ($urandom_range(0, 5) != 0);
      bus.aref_req_i  = ($urandom_range(0, 3) == 0);
      bus.wr_req_i    = $urandom_range(0, 1) == 1;
      bus.rd_req_i    = $urandom_range(0, 1) == 1;
      bus.aref_end_i  = ($urandom_range(0, 3) == 0);
      bus.wr_end_i    = ($urandom_range(0, 3) == 0);
      bus.rd_end_i    = ($urandom_range(0, 3) == 0);
      bus.init_cmd_i  = 4'($urandom);
      bus.aref_cmd_i  = 4'($urandom);
      bus.wr_cmd_i    = 4'($urandom);
      bus.rd_cmd_i    = 4'($urandom);
      bus.init_ba_i   = BW'($urandom);
      bus.aref_ba_i   = BW'($urandom);
      bus.wr_ba_i     = BW'($urandom);
      bus.rd_ba_i     = BW'($urandom);
      bus.init_addr_i = AW'($urandom);
      bus.aref_addr_i = AW'($urandom);
      bus.wr_addr_i   = AW'($urandom);
      bus.rd_addr_i   = AW'($urandom);
      cyc();
      total++;
      if (grant() !== exp_grant()) begin
        bad++; $display("FAIL rand_grant n=%0d got=%b exp=%b", n, grant(), exp_grant());
      end
      total++;
      if (pins() !== exp_pins()) begin
        bad++; $display("FAIL rand_pins n=%0d got=%h exp=%h", n, pins(), exp_pins());
      end
    end
  endtask

  initial begin
    sys_rst_n       = 1'b0;
    bus.init_end_i  = 1'b0;
    bus.init_cmd_i  = '0;
    bus.init_ba_i   = '0;
    bus.init_addr_i = '0;
    bus.aref_req_i  = 1'b0;
    bus.aref_end_i  = 1'b0;
    bus.aref_cmd_i  = '0;
    bus.aref_ba_i   = '0;
    bus.aref_addr_i = '0;
    bus.wr_req_i    = 1'b0;
    bus.wr_end_i    = 1'b0;
    bus.wr_cmd_i    = 4'b0100;
    bus.wr_ba_i     = '0;
    bus.wr_addr_i   = '0;
    bus.rd_req_i    = 1'b0;
    bus.rd_end_i    = 1'b0;
    bus.rd_cmd_i    = 4'b0101;
    bus.rd_ba_i     = '0;
    bus.rd_addr_i   = '0;

    test_reset();
    test_refresh();
    test_contention();
    test_no_preempt();
    test_stray_end();
    test_mid_reset();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
